reservoir_loader: RTL and testbench

Front-end frame collector for the integer echo-state network. It accepts reservoir samples one at a time over a valid/ready handshake and packs them into the flat reservoir vector. It issues the single-cycle start pulse to the interpreter stage, then holds the frame stable until the interpreter reports completion. It sits directly upstream of the interpreter: it drives that stage's `iData` and `iEn`, and consumes its `oIntRdy`.

---
 rtl/reservoir_loader.sv | 169 ++++++++++++++++
 tb/tb_reservoir_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reservoir_loader.sv
// -----------------------------------------------------------------------------
// reservoir_loader
//
// Front-end frame collector for the integer echo-state network. Samples arrive
// one at a time over a valid/ready handshake and are packed into a flat
// reservoir vector. Once a frame is complete it is presented to the
// interpreter stage with a single-cycle start pulse. The frame is then held
// stable until the interpreter signals completion with a rising edge on
// iIntRdy.
//
// Optional feature (macro LOADER_DOUBLE_BUF_EN):
//   While the interpreter works on one frame, the next frame is collected
//   into the shadow register and launched directly on completion.
//
// Ports:
//   iClk         in   rising-edge clock
//   iRstN        in   asynchronous active-low reset
//   iValid       in   sample strobe
//   iSample      in   sample value [data_width]
//   oReady       out  loader accepts a sample this cycle
//   oData        out  packed frame, slot k at [k*data_width +: data_width]
//   oEn          out  one-cycle start pulse to the interpreter
//   iIntRdy      in   interpreter completion (may be level-held)
//   oBusy        out  a frame is launched and not yet complete
//   oFrameCount  out  completed frames, wraps modulo 2^cnt_width
// -----------------------------------------------------------------------------
module reservoir_loader #(
    parameter int data_width     = 3,
    parameter int reservoir_size = 4,
    parameter int cnt_width      = 8
) (
    input  logic                               iClk,
    input  logic                               iRstN,
    input  logic                               iValid,
    input  logic [data_width-1:0]              iSample,
    output logic                               oReady,
    output logic [reservoir_size*data_width-1:0] oData,
    output logic                               oEn,
    input  logic                               iIntRdy,
    output logic                               oBusy,
    output logic [cnt_width-1:0]               oFrameCount
);

    localparam int FW    = reservoir_size * data_width;
    localparam int IDX_W = (reservoir_size > 1) ? $clog2(reservoir_size) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(reservoir_size - 1);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [FW-1:0]        r_shadow;
    logic [FW-1:0]        r_data;
    logic                 r_en;
    logic                 r_rdyQ;
    logic [cnt_width-1:0] r_frameCount;
`ifdef LOADER_DOUBLE_BUF_EN
    logic                 r_pending;
`endif

    logic          w_transfer;
    logic          w_lastSample;
    logic          w_complete;
    logic [FW-1:0] w_frame;

`ifdef LOADER_DOUBLE_BUF_EN
    // A second frame may be collected during the wait, but only one can be
    // parked in the shadow register at a time.
    assign oReady = (r_state == FILL) || ((r_state == WAIT_RES) && !r_pending);
`else
    assign oReady = (r_state == FILL);
`endif

    assign oBusy        = (r_state != FILL);
    assign oData        = r_data;
    assign oEn          = r_en;
    assign oFrameCount  = r_frameCount;

    assign w_transfer   = iValid && oReady;
    assign w_lastSample = (r_idx == LAST_IDX);

    // Only a fresh rising edge seen while waiting counts; a level left high
    // from the previous frame or an edge during LAUNCH is not a completion.
    assign w_complete   = iIntRdy && !r_rdyQ && (r_state == WAIT_RES);

    // Shadow contents with the incoming sample merged into the current slot,
    // so the last sample of a frame can be forwarded in the same edge.
    always_comb begin
        w_frame = r_shadow;
        w_frame[r_idx*data_width +: data_width] = iSample;
    end

    // Single FSM: sample collection, launch pulse, completion tracking and
    // frame counting all live here so every output is registered together.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_data       <= '0;
            r_en         <= 1'b0;
            r_rdyQ       <= 1'b0;
            r_frameCount <= '0;
`ifdef LOADER_DOUBLE_BUF_EN
            r_pending    <= 1'b0;
`endif
        end else begin
            r_rdyQ <= iIntRdy;
            r_en   <= 1'b0;

            if (w_transfer) begin
                r_shadow <= w_frame;
                r_idx    <= w_lastSample ? '0 : r_idx + 1'b1;
            end

            case (r_state)
                FILL: begin
                    if (w_transfer && w_lastSample) begin
                        r_data  <= w_frame;
                        r_en    <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    r_state <= WAIT_RES;
                end

                WAIT_RES: begin
`ifdef LOADER_DOUBLE_BUF_EN
                    if (w_complete) begin
                        r_frameCount <= r_frameCount + 1'b1;
                        if (r_pending) begin
                            r_data    <= r_shadow;
                            r_pending <= 1'b0;
                            r_en      <= 1'b1;
                            r_state   <= LAUNCH;
                        end else if (w_transfer && w_lastSample) begin
                            // Next frame finished on the completion edge:
                            // launch it directly instead of parking it.
                            r_data  <= w_frame;
                            r_en    <= 1'b1;
                            r_state <= LAUNCH;
                        end else begin
                            r_state <= FILL;
                        end
                    end else if (w_transfer && w_lastSample) begin
                        r_pending <= 1'b1;
                    end
`else
                    if (w_complete) begin
                        r_frameCount <= r_frameCount + 1'b1;
                        r_state      <= FILL;
                    end
`endif
                end

                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reservoir_loader.sv
// -----------------------------------------------------------------------------
// tb_reservoir_loader
//
// Self-checking bench for reservoir_loader. Inputs are driven and outputs
// sampled on the falling clock edge. Expected frames are packed from the
// sample lists with plain arithmetic and the expected frame count is a simple
// modulo counter of completions.
// -----------------------------------------------------------------------------
module tb_reservoir_loader;

    localparam int DW = 3;
    localparam int RS = 4;
    localparam int CW = 8;
    localparam int FW = RS * DW;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic          iValid;
    logic [DW-1:0] iSample;
    logic          oReady;
    logic [FW-1:0] oData;
    logic          oEn;
    logic          iIntRdy;
    logic          oBusy;
    logic [CW-1:0] oFrameCount;

    int errors   = 0;
    int checks   = 0;
    int expCount = 0;

    reservoir_loader #(
        .data_width    (DW),
        .reservoir_size(RS),
        .cnt_width     (CW)
    ) dut (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .iValid     (iValid),
        .iSample    (iSample),
        .oReady     (oReady),
        .oData      (oData),
        .oEn        (oEn),
        .iIntRdy    (iIntRdy),
        .oBusy      (oBusy),
        .oFrameCount(oFrameCount)
    );

    always #5 iClk = ~iClk;

    // Reference packing: slot k holds sample k, weighted by 2^(k*DW).
    function automatic logic [FW-1:0] packFrame(input int v[RS]);
        logic [FW-1:0] acc;
        acc = '0;
        for (int k = 0; k < RS; k++) begin
            acc = acc + (FW'(v[k] % (1 << DW)) << (k * DW));
        end
        return acc;
    endfunction

    function automatic int nextCount(input int c);
        return (c + 1) % (1 << CW);
    endfunction

    // Presents one sample per transfer with random idle gaps; returns on the
    // falling edge right after the last sample was accepted.
    task automatic pushFrame(input int v[RS], input int maxGap);
        int gap;
        for (int k = 0; k < RS; k++) begin
            gap = $urandom_range(0, maxGap);
            iValid = 1'b0;
            repeat (gap) @(negedge iClk);
            iValid  = 1'b1;
            iSample = DW'(v[k]);
            @(negedge iClk);
        end
        iValid = 1'b0;
    endtask

    // Keeps iIntRdy low for lat cycles, then raises it; returns on the
    // falling edge right after the completion edge.
    task automatic waitComplete(input int lat);
        iIntRdy = 1'b0;
        repeat (lat) @(negedge iClk);
        iIntRdy = 1'b1;
        @(negedge iClk);
    endtask

    task automatic randomFrame(output int v[RS]);
        for (int k = 0; k < RS; k++) v[k] = $urandom_range(0, (1 << DW) - 1);
    endtask

    task automatic test_reset;
        iRstN   = 1'b0;
        iValid  = 1'b0;
        iSample = '0;
        iIntRdy = 1'b0;
        repeat (2) @(negedge iClk);
        checks++; if (oData !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected %h", oData, {FW{1'b0}}); end
        checks++; if (oEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", oEn); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", oBusy); end
        checks++; if (oFrameCount !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", oFrameCount); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", oReady); end
        iRstN = 1'b1;
        expCount = 0;
        @(negedge iClk);
    endtask

    // Ends in WAIT_RES with the frame 1,2,3,4 outstanding.
    task automatic test_basic_frame;
        int v[RS];
        v = '{1, 2, 3, 4};
        pushFrame(v, 0);
        checks++; if (oData !== 12'h8D1) begin errors++; $display("[TB] FAIL basic_data: got %h expected 8d1", oData); end
        checks++; if (oEn !== 1'b1) begin errors++; $display("[TB] FAIL basic_en_pulse: got %b expected 1", oEn); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", oBusy); end
        checks++; if (oReady !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_launch: got %b expected 0", oReady); end
        @(negedge iClk);
        checks++; if (oEn !== 1'b0) begin errors++; $display("[TB] FAIL basic_en_drop: got %b expected 0", oEn); end
        checks++; if (oData !== 12'h8D1) begin errors++; $display("[TB] FAIL basic_data_hold: got %h expected 8d1", oData); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_wait: got %b expected 1", oBusy); end
    endtask

    // Completes the outstanding frame with a long-held iIntRdy.
    task automatic test_stale_ready;
        int v[RS];
        iIntRdy = 1'b1;
        @(negedge iClk);
        expCount = nextCount(expCount);
        checks++; if (oFrameCount !== CW'(expCount)) begin errors++; $display("[TB] FAIL stale_first: got %0d expected %0d", oFrameCount, expCount); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL stale_ready_back: got %b expected 1", oReady); end
        repeat (4) @(negedge iClk);
        checks++; if (oFrameCount !== CW'(expCount)) begin errors++; $display("[TB] FAIL stale_held: got %0d expected %0d", oFrameCount, expCount); end
        randomFrame(v);
        pushFrame(v, 1);
        checks++; if (oData !== packFrame(v)) begin errors++; $display("[TB] FAIL stale_next_data: got %h expected %h", oData, packFrame(v)); end
        repeat (4) @(negedge iClk);
        checks++; if (oFrameCount !== CW'(expCount)) begin errors++; $display("[TB] FAIL stale_no_complete: got %0d expected %0d", oFrameCount, expCount); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL stale_still_busy: got %b expected 1", oBusy); end
        waitComplete(2);
        expCount = nextCount(expCount);
        checks++; if (oFrameCount !== CW'(expCount)) begin errors++; $display("[TB] FAIL stale_second: got %0d expected %0d", oFrameCount, expCount); end
        iIntRdy = 1'b0;
    endtask

    task automatic test_ignored_valid;
`ifndef LOADER_DOUBLE_BUF_EN
        int v[RS];
        int w[RS];
        logic [FW-1:0] held;
        randomFrame(v);
        pushFrame(v, 0);
        held = packFrame(v);
        iValid  = 1'b1;
        iSample = 3'd7;
        repeat (3) @(negedge iClk);
        checks++; if (oReady !== 1'b0) begin errors++; $display("[TB] FAIL ignored_ready: got %b expected 0", oReady); end
        checks++; if (oData !== held) begin errors++; $display("[TB] FAIL ignored_data_hold: got %h expected %h", oData, held); end
        waitComplete(1);
        iValid = 1'b0;
        expCount = nextCount(expCount);
        checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL ignored_ready_back: got %b expected 1", oReady); end
        w = '{2, 5, 0, 6};
        pushFrame(w, 0);
        checks++; if (oData !== packFrame(w)) begin errors++; $display("[TB] FAIL ignored_next_frame: got %h expected %h", oData, packFrame(w)); end
        @(negedge iClk);
        waitComplete(1);
        expCount = nextCount(expCount);
        checks++; if (oFrameCount !== CW'(expCount)) begin errors++; $display("[TB] FAIL ignored_count: got %0d expected %0d", oFrameCount, expCount); end
        iIntRdy = 1'b0;
`endif
    endtask

    task automatic test_reset_midframe;
        int v[RS];
        iValid = 1'b1; iSample = 3'd3; @(negedge iClk);
        iValid = 1'b1; iSample = 3'd6; @(negedge iClk);
        iValid = 1'b0;
        #2 iRstN = 1'b0;
        #1;
        checks++; if (oData !== '0) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 0", oData); end
        checks++; if (oFrameCount !== '0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", oFrameCount); end
        checks++; if (oReady !== 1'b1 || oBusy !== 1'b0 || oEn !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got ready=%b busy=%b en=%b expected 1 0 0", oReady, oBusy, oEn); end
        @(negedge iClk);
        iRstN = 1'b1;
        expCount = 0;
        @(negedge iClk);
        v = '{5, 5, 5, 5};
        pushFrame(v, 0);
        checks++; if (oData !== 12'hB6D) begin errors++; $display("[TB] FAIL midrst_frame: got %h expected b6d", oData); end
        @(negedge iClk);
        waitComplete(3);
        expCount = nextCount(expCount);
        checks++; if (oFrameCount !== CW'(expCount)) begin errors++; $display("[TB] FAIL midrst_complete: got %0d expected %0d", oFrameCount, expCount); end
        iIntRdy = 1'b0;
    endtask

    // Random frames with random gaps and interpreter latency until the
    // counter wraps back to zero.
    task automatic test_wrap;
        int v[RS];
        int frames;
        frames = (1 << CW) - expCount;
        for (int f = 0; f < frames; f++) begin
            randomFrame(v);
            pushFrame(v, 2);
            checks++; if (oData !== packFrame(v) || oEn !== 1'b1) begin errors++; $display("[TB] FAIL wrap_frame%0d: got %h en=%b expected %h en=1", f, oData, oEn, packFrame(v)); end
            @(negedge iClk);
            waitComplete($urandom_range(1, 4));
            expCount = nextCount(expCount);
            checks++; if (oFrameCount !== CW'(expCount) || oBusy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_count%0d: got %0d busy=%b expected %0d busy=0", f, oFrameCount, oBusy, expCount); end
            iIntRdy = 1'b0;
        end
        checks++; if (oFrameCount !== '0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d expected 0", oFrameCount); end
    endtask

    task automatic test_double_buf;
`ifdef LOADER_DOUBLE_BUF_EN
        int a[RS];
        int b[RS];
        randomFrame(a);
        pushFrame(a, 1);
        @(negedge iClk);
        checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL dbuf_ready_wait: got %b expected 1", oReady); end
        b = '{7, 0, 0, 0};
        pushFrame(b, 0);
        checks++; if (oReady !== 1'b0) begin errors++; $display("[TB] FAIL dbuf_ready_full: got %b expected 0", oReady); end
        checks++; if (oData !== packFrame(a) || oEn !== 1'b0) begin errors++; $display("[TB] FAIL dbuf_data_hold: got %h en=%b expected %h en=0", oData, oEn, packFrame(a)); end
        waitComplete(1);
        expCount = nextCount(expCount);
        checks++; if (oEn !== 1'b1 || oData !== 12'h007) begin errors++; $display("[TB] FAIL dbuf_relaunch: got en=%b data=%h expected en=1 data=007", oEn, oData); end
        checks++; if (oFrameCount !== CW'(expCount) || oReady !== 1'b0) begin errors++; $display("[TB] FAIL dbuf_count: got %0d ready=%b expected %0d ready=0", oFrameCount, oReady, expCount); end
        @(negedge iClk);
        checks++; if (oEn !== 1'b0 || oBusy !== 1'b1) begin errors++; $display("[TB] FAIL dbuf_en_drop: got en=%b busy=%b expected 0 1", oEn, oBusy); end
        waitComplete(1);
        expCount = nextCount(expCount);
        checks++; if (oFrameCount !== CW'(expCount) || oBusy !== 1'b0) begin errors++; $display("[TB] FAIL dbuf_final: got %0d busy=%b expected %0d busy=0", oFrameCount, oBusy, expCount); end
        iIntRdy = 1'b0;
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_stale_ready();
        test_ignored_valid();
        test_reset_midframe();
        test_wrap();
        test_double_buf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
